// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite upstream arbiter.
// Holds the arbitration FSM state encoding and the grant-index width helper.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4
  } arb_state_t;

  // A single master still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle used between the masters, the arbiter and the crossbar.
// Response fields are one bit wide; write strobes are one bit per byte lane.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wmask, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_grant,
// wrapping around, so last_grant itself has the lowest priority.
module rr_picker
  import axi_arb_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int IDX_W      = idx_w(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      last_grant,
  output logic                  any,
  output logic [IDX_W-1:0]      grant
);

  int idx;

  // Scan from lowest to highest priority so the nearest requester is written last.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = MASTER_NUM; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % MASTER_NUM;
      if (req[idx]) begin
        any   = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N:1 AXI4-Lite arbiter feeding the crossbar: one whole read or write transaction
// at a time, round-robin between masters, one outstanding downstream transaction.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int MASTER_NUM = 2
) (
  input logic       clk,
  input logic       reset,
  axi_lite_if.slave m [MASTER_NUM],
  axi_lite_if.master s
);

  localparam int IDX_W = idx_w(MASTER_NUM);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] g, g_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic             aw_done, aw_done_nxt;
  logic             w_done, w_done_nxt;

  logic [MASTER_NUM-1:0] req;
  logic                  pick_any;
  logic [IDX_W-1:0]      pick;

  logic [31:0] m_araddr  [MASTER_NUM];
  logic [31:0] m_awaddr  [MASTER_NUM];
  logic [31:0] m_wdata   [MASTER_NUM];
  logic [3:0]  m_wmask   [MASTER_NUM];
  logic        m_arvalid [MASTER_NUM];
  logic        m_awvalid [MASTER_NUM];
  logic        m_wvalid  [MASTER_NUM];
  logic        m_rready  [MASTER_NUM];
  logic        m_bready  [MASTER_NUM];

  // Per-master unpacking and return-path gating: only the granted master sees responses.
  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_port
    logic sel;
    assign sel = (g == IDX_W'(i));

    assign m_araddr[i]  = m[i].araddr;
    assign m_awaddr[i]  = m[i].awaddr;
    assign m_wdata[i]   = m[i].wdata;
    assign m_wmask[i]   = m[i].wmask;
    assign m_arvalid[i] = m[i].arvalid;
    assign m_awvalid[i] = m[i].awvalid;
    assign m_wvalid[i]  = m[i].wvalid;
    assign m_rready[i]  = m[i].rready;
    assign m_bready[i]  = m[i].bready;
    assign req[i]       = m[i].arvalid | m[i].awvalid;

    assign m[i].arready = sel && (state == RD_A) && s.arready;
    assign m[i].rvalid  = sel && (state == RD_D) && s.rvalid;
    assign m[i].rdata   = (sel && (state == RD_D)) ? s.rdata : '0;
    assign m[i].rresp   = sel && (state == RD_D) && s.rresp;
    assign m[i].awready = sel && (state == WR_A) && !aw_done && s.awready;
    assign m[i].wready  = sel && (state == WR_A) && !w_done && s.wready;
    assign m[i].bvalid  = sel && (state == WR_B) && s.bvalid;
    assign m[i].bresp   = sel && (state == WR_B) && s.bresp;
  end

  rr_picker #(
    .MASTER_NUM (MASTER_NUM),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .any        (pick_any),
    .grant      (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= IDX_W'(MASTER_NUM - 1);
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      g          <= g_nxt;
      last_grant <= last_grant_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    g_nxt          = g;
    last_grant_nxt = last_grant;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;

    s.araddr  = '0;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    s.awaddr  = '0;
    s.awvalid = 1'b0;
    s.wdata   = '0;
    s.wmask   = '0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;

    case (state)
      IDLE: begin
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (pick_any) begin
          g_nxt     = pick;
          state_nxt = m_arvalid[pick] ? RD_A : WR_A;
        end
      end
      RD_A: begin
        s.arvalid = m_arvalid[g];
        s.araddr  = m_araddr[g];
        if (m_arvalid[g] && s.arready) state_nxt = RD_D;
      end
      RD_D: begin
        s.rready = m_rready[g];
        if (s.rvalid && m_rready[g]) begin
          state_nxt      = IDLE;
          last_grant_nxt = g;
        end
      end
      WR_A: begin
        // AW and W complete independently; each is masked once it has been accepted.
        s.awvalid   = m_awvalid[g] && !aw_done;
        s.awaddr    = m_awaddr[g];
        s.wvalid    = m_wvalid[g] && !w_done;
        s.wdata     = m_wdata[g];
        s.wmask     = m_wmask[g];
        aw_done_nxt = aw_done || (m_awvalid[g] && s.awready);
        w_done_nxt  = w_done || (m_wvalid[g] && s.wready);
        if (aw_done_nxt && w_done_nxt) state_nxt = WR_B;
      end
      WR_B: begin
        s.bready = m_bready[g];
        if (s.bvalid && m_bready[g]) begin
          state_nxt      = IDLE;
          last_grant_nxt = g;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
